// File: rtl/stb_gen_pkg.sv
// Types and constants shared between stb_gen and its measurement controller.
package stb_gen_pkg;

  localparam int unsigned STB_T_CNT_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_SAMPLE,
    ST_RETRY,
    ST_DONE,
    ST_FAIL
  } stb_ctrl_state_t;

  function automatic logic is_busy(input stb_ctrl_state_t s);
    return (s == ST_ARM) || (s == ST_WAIT) || (s == ST_SAMPLE) || (s == ST_RETRY);
  endfunction

endpackage

// File: rtl/stb_gen_ctrl_if.sv
// Command, stb_gen handshake and status bundle of the measurement controller.
interface stb_gen_ctrl_if
  import stb_gen_pkg::*;
#(
  parameter int unsigned T_CNT_WIDTH = STB_T_CNT_WIDTH
) ();

  logic                   start_i;
  logic                   stop_i;
  logic                   run_det_o;
  logic                   oe_o;
  logic                   rdy_i;
  logic                   err_i;
  logic [T_CNT_WIDTH-1:0] stb_period_i;
  logic [T_CNT_WIDTH-1:0] period_o;
  logic                   locked_o;
  logic                   fail_o;
  logic                   busy_o;

  modport master (
    input  start_i, stop_i, rdy_i, err_i, stb_period_i,
    output run_det_o, oe_o, period_o, locked_o, fail_o, busy_o
  );

  modport slave (
    output start_i, stop_i, rdy_i, err_i, stb_period_i,
    input  run_det_o, oe_o, period_o, locked_o, fail_o, busy_o
  );

endinterface

// File: rtl/stb_avg_acc.sv
// Period sample store: 2**AVG_LOG2-sample accumulator with STB_GEN_CTRL_AVG_EN,
// otherwise a single captured sample.
module stb_avg_acc #(
  parameter int unsigned T_CNT_WIDTH = 12,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clr_i,
  input  logic                   add_i,
  input  logic [T_CNT_WIDTH-1:0] sample_i,
  output logic                   full_o,
  output logic [T_CNT_WIDTH-1:0] avg_o
);

`ifdef STB_GEN_CTRL_AVG_EN
  localparam int unsigned ACC_W = T_CNT_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_q + ACC_W'(sample_i);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign full_o = (cnt_q == N_SAMPLES);
  assign avg_o  = T_CNT_WIDTH'(acc_q >> AVG_LOG2);
`else
  logic [T_CNT_WIDTH-1:0] smp_q;
  logic                   vld_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      smp_q <= '0;
      vld_q <= 1'b0;
    end else if (clr_i) begin
      smp_q <= '0;
      vld_q <= 1'b0;
    end else if (add_i) begin
      smp_q <= sample_i;
      vld_q <= 1'b1;
    end
  end

  assign full_o = vld_q;
  assign avg_o  = smp_q;
`endif

endmodule

// File: rtl/stb_gen_ctrl.sv
// Measurement sequencer for stb_gen: arm, wait with timeout, retry, average, lock.
// Averaging over 2**AVG_LOG2 samples is built only with STB_GEN_CTRL_AVG_EN.
module stb_gen_ctrl
  import stb_gen_pkg::*;
#(
  parameter int unsigned T_CNT_WIDTH = STB_T_CNT_WIDTH,
  parameter int unsigned TO_WIDTH    = 20,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic           clk_i,
  input  logic           arst_i,
  stb_gen_ctrl_if.master bus
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  stb_ctrl_state_t        state_q, state_d;
  logic                   arm_q, arm_d;
  logic [TO_WIDTH-1:0]    to_q, to_d, to_inc;
  logic [RETRY_W-1:0]     retry_q, retry_d, retry_inc;
  logic                   acc_clr, acc_add, acc_full;
  logic [T_CNT_WIDTH-1:0] acc_avg;

  logic                   run_det_q, oe_q, locked_q, fail_q, busy_q;
  logic [T_CNT_WIDTH-1:0] period_q;

  stb_avg_acc #(
    .T_CNT_WIDTH (T_CNT_WIDTH),
    .AVG_LOG2    (AVG_LOG2)
  ) u_acc (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .clr_i    (acc_clr),
    .add_i    (acc_add),
    .sample_i (bus.stb_period_i),
    .full_o   (acc_full),
    .avg_o    (acc_avg)
  );

  assign to_inc    = to_q + TO_WIDTH'(1);
  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d = state_q;
    arm_d   = 1'b0;
    to_d    = to_q;
    retry_d = retry_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start_i) begin
          state_d = ST_ARM;
          retry_d = '0;
          acc_clr = 1'b1;
        end
      end
      ST_ARM: begin
        to_d = '0;
        if (arm_q) state_d = ST_WAIT;
        else       arm_d   = 1'b1;
      end
      ST_WAIT: begin
        // The sample is taken on the rdy_i edge so SAMPLE already sees the updated count.
        to_d = to_inc;
        if (bus.err_i) begin
          state_d = ST_RETRY;
        end else if (bus.rdy_i) begin
          state_d = ST_SAMPLE;
          acc_add = 1'b1;
        end else if (to_inc == '1) begin
          state_d = ST_RETRY;
        end
      end
      ST_SAMPLE: state_d = acc_full ? ST_DONE : ST_ARM;
      ST_RETRY: begin
        retry_d = retry_inc;
        state_d = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.stop_i) begin
      state_d = ST_IDLE;
      acc_add = 1'b0;
      acc_clr = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      to_q      <= '0;
      retry_q   <= '0;
      run_det_q <= 1'b0;
      oe_q      <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      run_det_q <= (state_d == ST_ARM);
      oe_q      <= (state_d == ST_DONE);
      locked_q  <= (state_d == ST_DONE);
      fail_q    <= (state_d == ST_FAIL);
      busy_q    <= is_busy(state_d);
      if (state_q == ST_SAMPLE && state_d == ST_DONE) period_q <= acc_avg;
    end
  end

  assign bus.run_det_o = run_det_q;
  assign bus.oe_o      = oe_q;
  assign bus.locked_o  = locked_q;
  assign bus.fail_o    = fail_q;
  assign bus.busy_o    = busy_q;
  assign bus.period_o  = period_q;

endmodule

// File: doc/stb_gen_ctrl.md
STB_GEN_CTRL -- requirements
Module: stb_gen_ctrl

Interface
REQ-001 SHALL have parameter T_CNT_WIDTH, default 12, width of stb_gen period count.
REQ-002 SHALL have parameter TO_WIDTH, default 20, width of per-attempt timeout counter.
REQ-003 SHALL have parameter MAX_RETRY, default 3, failed attempts tolerated before FAIL.
REQ-004 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start_i  input  1  one-cycle request to begin a measurement sequence.
REQ-008 SHALL have port stop_i  input  1  one-cycle abort, returns to IDLE.
REQ-009 SHALL have port run_det_o  output  1  detection trigger to stb_gen.
REQ-010 SHALL have port oe_o  output  1  strobe output enable to stb_gen.
REQ-011 SHALL have port rdy_i  input  1  stb_gen period measured.
REQ-012 SHALL have port err_i  input  1  stb_gen measurement error.
REQ-013 SHALL have port stb_period_i  input  T_CNT_WIDTH  measured period in clk cycles.
REQ-014 SHALL have port period_o  output  T_CNT_WIDTH  final (averaged) period.
REQ-015 SHALL have ports locked_o, fail_o, busy_o  output  1 each  status flags.

Function
REQ-016 SHALL implement states IDLE, ARM, WAIT, SAMPLE, RETRY, DONE, FAIL; all outputs registered.
REQ-017 IDLE: start_i -> ARM; clears retry count, sample count, accumulator.
REQ-018 ARM: run_det_o=1 for exactly 2 cycles, timeout counter cleared, then WAIT.
REQ-019 WAIT: timeout counter +1 per cycle; err_i=1 -> RETRY; rdy_i=1 with err_i=0 -> SAMPLE; counter all-ones without rdy_i -> RETRY.
REQ-020 rdy_i and err_i both high in same cycle SHALL be treated as error.
REQ-021 SAMPLE: accumulator (T_CNT_WIDTH+AVG_LOG2 bits, no overflow possible) += stb_period_i; sample count +1; count == 2**AVG_LOG2 -> DONE, else ARM.
REQ-022 RETRY: retry count +1; reaching MAX_RETRY -> FAIL, else ARM; accumulated samples retained.
REQ-023 DONE: period_o = accumulator >> AVG_LOG2 (truncate), locked_o=1, oe_o=1, held.
REQ-024 FAIL: fail_o=1, oe_o=0, period_o unchanged, held.
REQ-025 busy_o=1 in ARM, WAIT, SAMPLE, RETRY; 0 otherwise.
REQ-026 start_i SHALL be ignored while busy_o=1; in DONE/FAIL it restarts as from IDLE, clearing locked_o/fail_o.
REQ-027 stop_i in any state -> IDLE next cycle, run_det_o=0, oe_o=0, locked_o=0; stop_i wins over simultaneous start_i.
REQ-028 rdy_i/err_i outside WAIT SHALL be ignored.

Reset
REQ-029 arst_i SHALL force IDLE immediately; run_det_o, oe_o, locked_o, fail_o, busy_o=0; period_o=0; all counters=0, including mid-sequence.

Configuration
REQ-030 With STB_GEN_CTRL_AVG_EN defined, averaging per REQ-021/023 SHALL be built.
REQ-031 Without STB_GEN_CTRL_AVG_EN, AVG_LOG2 SHALL be ignored, one sample taken, period_o = stb_period_i, no accumulator logic.

Structure
REQ-032 Package stb_gen_pkg SHALL hold the state enum and default T_CNT_WIDTH constant shared with stb_gen.
REQ-033 Sub-module stb_avg_acc SHALL implement accumulator, sample counter and shift.

Verification
REQ-034 AVG_EN, AVG_LOG2=2, periods 125,125,126,124 -> period_o=125, locked_o=1, oe_o=1 after 4th SAMPLE.
REQ-035 err_i on first attempt, then rdy_i with 200 -> one RETRY, locked_o=1, period_o=200 (AVG off).
REQ-036 MAX_RETRY=3, err_i every attempt -> fail_o=1 after 3rd error, run_det_o pulsed exactly 3 times, oe_o=0.
REQ-037 TO_WIDTH=8, rdy_i never asserted -> RETRY after 255 WAIT cycles each attempt, then FAIL.
REQ-038 stop_i during WAIT with start_i same cycle -> IDLE next cycle, busy_o=0, no further run_det_o.
REQ-039 arst_i asserted mid-ARM -> run_det_o=0 immediately, all outputs 0; fresh start_i completes normally.
